// File: rtl/ps2_pong_keys_pkg.sv
// Shared constants for the pong keyboard front end: scancodes, action-bit
// positions, decoder state encodings and the scancode-to-action mapping.
package ps2_pong_keys_pkg;

  // Set-2 scancodes of interest
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_LEFT  = 8'h6B;  // only meaningful after E0
  localparam logic [7:0] SC_RIGHT = 8'h74;  // only meaningful after E0
  localparam logic [7:0] SC_SPACE = 8'h29;

  // Bit positions inside mAccion
  localparam int ACT_W        = 5;
  localparam int ACT_SPACE    = 0;
  localparam int ACT_B1_LEFT  = 1;
  localparam int ACT_B1_RIGHT = 2;
  localparam int ACT_B0_RIGHT = 3;
  localparam int ACT_B0_LEFT  = 4;

  // Decoder states; BRK carries a separate ext flag register
  localparam logic [1:0] DEC_BASE = 2'd0;
  localparam logic [1:0] DEC_EXT  = 2'd1;
  localparam logic [1:0] DEC_BRK  = 2'd2;

  // One-hot action mask for a code; zero for keys the game does not use
  function automatic logic [ACT_W-1:0] key_mask(input logic ext, input logic [7:0] code);
    logic [ACT_W-1:0] m;
    m = '0;
    if (!ext) begin
      case (code)
        SC_A:     m[ACT_B0_LEFT]  = 1'b1;
        SC_D:     m[ACT_B0_RIGHT] = 1'b1;
        SC_SPACE: m[ACT_SPACE]    = 1'b1;
        default:  m = '0;
      endcase
    end else begin
      case (code)
        SC_LEFT:  m[ACT_B1_LEFT]  = 1'b1;
        SC_RIGHT: m[ACT_B1_RIGHT] = 1'b1;
        default:  m = '0;
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/ps2_pong_keys_rx.sv
// PS/2 receiver (ps2_rx): synchronizes the raw PS/2 lines, samples data on
// falling clock edges, assembles 11-bit frames, checks start/odd parity/stop
// and aborts a frame whose edges stop arriving.
module ps2_pong_keys_rx #(
  parameter int TIMEOUT_CYCLES = 25000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic          clk_meta, clk_sync, clk_prev;
  logic          data_meta, data_sync;
  logic          fall;
  logic [3:0]    bit_cnt;
  logic [9:0]    frame_q;   // start, d0..d7, parity once ten bits are in
  logic [TW-1:0] tmo_cnt;
  logic          frame_ok;

  // Two-flop synchronizers plus the previous synced clock for edge detection
  always_ff @(posedge clk) begin
    // NOTE: sequential state always uses non-blocking assignments so every
    // flop samples pre-edge values regardless of statement order.
    if (rst) begin
      // Idle-high reset values keep a reset release from looking like an edge
      clk_meta  <= 1'b1;
      clk_sync  <= 1'b1;
      clk_prev  <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      clk_meta  <= ps2_clk;
      clk_sync  <= clk_meta;
      clk_prev  <= clk_sync;
      data_meta <= ps2_data;
      data_sync <= data_meta;
    end
  end

  assign fall = clk_prev & ~clk_sync;

  // On the stop-bit edge data_sync holds the stop bit itself
  assign frame_ok = ~frame_q[0] & (^frame_q[9:1]) & data_sync;

  // Frame assembly, checking and inter-edge timeout
  always_ff @(posedge clk) begin
    rx_valid  <= 1'b0;
    frame_err <= 1'b0;
    if (rst) begin
      bit_cnt <= '0;
      frame_q <= '0;
      tmo_cnt <= '0;
      rx_byte <= '0;
    end else if (fall) begin
      tmo_cnt <= '0;
      if (bit_cnt == 4'd10) begin
        bit_cnt <= '0;
        if (frame_ok) begin
          rx_byte  <= frame_q[8:1];
          rx_valid <= 1'b1;
        end else begin
          frame_err <= 1'b1;
        end
      end else begin
        frame_q <= {data_sync, frame_q[9:1]};
        bit_cnt <= bit_cnt + 4'd1;
      end
    end else if (bit_cnt != 4'd0) begin
      if (tmo_cnt == TMO_LAST) begin
        bit_cnt   <= '0;
        tmo_cnt   <= '0;
        frame_err <= 1'b1;
      end else begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_pong_keys.sv
// Pong keyboard front end: decodes make/break sequences into a held-key
// vector and launches mAccion/bandera strobes on presses and on auto-repeat.
module ps2_pong_keys
  import ps2_pong_keys_pkg::*;
#(
  parameter int CLK_HZ         = 25000000,
  parameter int TIMEOUT_CYCLES = 25000,
  parameter int REPEAT_CYCLES  = 2500000,
  parameter int BANDERA_WIDTH  = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             ps2_clk,
  input  logic             ps2_data,
  output logic [ACT_W-1:0] mAccion,
  output logic             bandera,
  output logic [7:0]       rx_byte,
  output logic             rx_valid,
  output logic             frame_err
);

  if (CLK_HZ <= 0 || BANDERA_WIDTH < 1) begin : g_bad_params
    $error("ps2_pong_keys: CLK_HZ and BANDERA_WIDTH must be positive");
  end

  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  localparam int SW = $clog2(2 * BANDERA_WIDTH + 2);
  localparam logic [RW-1:0] RPT_LAST   = RW'(REPEAT_CYCLES - 1);
  localparam logic [SW-1:0] STR_RISE   = SW'(1);
  localparam logic [SW-1:0] STR_HI_END = SW'(BANDERA_WIDTH + 1);
  localparam logic [SW-1:0] STR_LAST   = SW'(2 * BANDERA_WIDTH + 1);

  logic [1:0]       dec_state, dec_next;
  logic             brk_ext, brk_ext_next;
  logic [ACT_W-1:0] held, held_next, key;
  logic             is_make, is_break, code_ext;
  logic             press_req, rep_req, req, launch, pending;
  logic [RW-1:0]    rep_cnt;
  logic [SW-1:0]    str_cnt;  // 0 idle, 1 launched, then high window, then min-low window

  ps2_pong_keys_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_ps2_rx (
    .clk      (Clock),
    .rst      (Reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .frame_err(frame_err)
  );

  // Prefix decoding and held-vector update for the byte received this cycle
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    dec_next     = dec_state;
    brk_ext_next = brk_ext;
    held_next    = held;
    press_req    = 1'b0;
    is_make      = 1'b0;
    is_break     = 1'b0;
    code_ext     = 1'b0;
    if (rx_valid) begin
      case (dec_state)
        DEC_EXT: begin
          if (rx_byte == SC_BRK) begin
            dec_next     = DEC_BRK;
            brk_ext_next = 1'b1;
          end else begin
            dec_next = DEC_BASE;
            is_make  = 1'b1;
            code_ext = 1'b1;
          end
        end
        DEC_BRK: begin
          dec_next = DEC_BASE;
          is_break = 1'b1;
          code_ext = brk_ext;
        end
        default: begin
          dec_next = DEC_BASE;
          if (rx_byte == SC_EXT) begin
            dec_next = DEC_EXT;
          end else if (rx_byte == SC_BRK) begin
            dec_next     = DEC_BRK;
            brk_ext_next = 1'b0;
          end else begin
            is_make = 1'b1;
          end
        end
      endcase
    end
    key = key_mask(code_ext, rx_byte);
    // Typematic makes of an already-held key are ignored
    if (is_make && key != '0 && (held & key) == '0) begin
      held_next = held | key;
      press_req = 1'b1;
    end
    if (is_break) begin
      held_next = held & ~key;
    end
  end

  assign rep_req = (held != '0) && (rep_cnt == RPT_LAST);
  assign req     = press_req | rep_req;
  assign launch  = (str_cnt == '0) && (req || pending);

  // Decoder state and held-key vector
  always_ff @(posedge Clock) begin
    if (Reset) begin
      dec_state <= DEC_BASE;
      brk_ext   <= 1'b0;
      held      <= '0;
    end else begin
      dec_state <= dec_next;
      brk_ext   <= brk_ext_next;
      held      <= held_next;
    end
  end

  // Strobe launch, bandera window, pending collapse and auto-repeat timer
  always_ff @(posedge Clock) begin
    if (Reset) begin
      mAccion <= '0;
      bandera <= 1'b0;
      str_cnt <= '0;
      pending <= 1'b0;
      rep_cnt <= '0;
    end else begin
      if (launch) begin
        mAccion <= held_next;
        str_cnt <= STR_RISE;
        pending <= 1'b0;
      end else begin
        // mAccion only otherwise moves when everything has been released
        if (held_next == '0) mAccion <= '0;
        // A request that cannot launch means the window is busy
        if (req) pending <= 1'b1;
        if (str_cnt == STR_LAST)   str_cnt <= '0;
        else if (str_cnt != '0)    str_cnt <= str_cnt + 1'b1;
      end

      if (str_cnt == STR_RISE)        bandera <= 1'b1;
      else if (str_cnt == STR_HI_END) bandera <= 1'b0;

      if (launch || held == '0 || rep_req) rep_cnt <= '0;
      else                                 rep_cnt <= rep_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ps2_pong_keys.sv
// Self-checking bench for ps2_pong_keys: directed PS/2 scenarios followed by
// random key events checked against an event-level held-key model.
module tb_ps2_pong_keys;

  localparam int H   = 20;    // PS/2 half bit period in system clocks
  localparam int TMO = 200;
  localparam int RPT = 2000;
  localparam int BW  = 4;

  localparam logic [7:0] KEY_CODE [5] = '{8'h1C, 8'h23, 8'h6B, 8'h74, 8'h29};
  localparam bit         KEY_EXT  [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  localparam int         KEY_BIT  [5] = '{4, 3, 1, 2, 0};

  logic       clk = 1'b0;
  logic       Reset, ps2_clk, ps2_data;
  logic [4:0] mAccion;
  logic       bandera, rx_valid, frame_err;
  logic [7:0] rx_byte;

  int n_tests = 0;
  int n_fail  = 0;

  // Monitor state, sampled on every falling system clock edge
  int         cyc = 0;
  int         rxv_cnt = 0;
  int         fe_cnt = 0;
  int         last_rxv = 0;
  logic       band_prev = 1'b0;
  int         rise_cyc[$];
  logic [4:0] mac_hist[int];
  logic       band_hist[int];

  ps2_pong_keys #(
    .CLK_HZ(25000000), .TIMEOUT_CYCLES(TMO), .REPEAT_CYCLES(RPT), .BANDERA_WIDTH(BW)
  ) dut (
    .Clock(clk), .Reset(Reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .mAccion(mAccion), .bandera(bandera), .rx_byte(rx_byte),
    .rx_valid(rx_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    mac_hist[cyc]  = mAccion;
    band_hist[cyc] = bandera;
    if (rx_valid === 1'b1) begin
      rxv_cnt++;
      last_rxv = cyc;
    end
    if (frame_err === 1'b1) fe_cnt++;
    if (bandera === 1'b1 && band_prev !== 1'b1) rise_cyc.push_back(cyc);
    band_prev = bandera;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    tick(H);
    ps2_clk = 1'b0;
    tick(H);
    ps2_clk = 1'b1;
  endtask

  // Sends the first nbits of a frame; bad_parity inverts the parity bit
  task automatic send_bits(input logic [7:0] b, input bit bad_parity, input int nbits);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_parity, b, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(f[i]);
    ps2_data = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(b, 1'b0, 11);
    tick(H);
  endtask

  function automatic int rises_between(input int a, input int b);
    int n;
    n = 0;
    foreach (rise_cyc[i]) if (rise_cyc[i] >= a && rise_cyc[i] <= b) n++;
    return n;
  endfunction

  function automatic int first_rise_after(input int a);
    foreach (rise_cyc[i]) if (rise_cyc[i] > a) return rise_cyc[i];
    return -1;
  endfunction

  function automatic bit is_special(input logic [7:0] c);
    return c == 8'hE0 || c == 8'hF0 || c == 8'h1C || c == 8'h23 ||
           c == 8'h29 || c == 8'h6B || c == 8'h74;
  endfunction

  initial begin
    int t1, t2, tb3, t5, t6, t6b, r1, r2, n0, f0, s0, wait_cnt, k, ki;
    logic [4:0] model;
    logic [7:0] code;

    Reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
    tick(5);
    Reset = 1'b0;
    tick(1);
    check("reset_mAccion", mAccion, 0);
    check("reset_bandera", bandera, 0);
    check("reset_rx_byte", rx_byte, 0);
    check("reset_rx_valid", rx_valid, 0);
    check("reset_frame_err", frame_err, 0);

    // Press A: launch at decode cycle, bandera high T+2..T+5
    n0 = rxv_cnt;
    send_byte(8'h1C);
    tick(10);
    t1 = last_rxv;
    check("t1_rx_valid_count", rxv_cnt - n0, 1);
    check("t1_rx_byte", rx_byte, 8'h1C);
    check("t1_mAccion_at_T", mac_hist[t1], 5'b00000);
    check("t1_mAccion_at_T1", mac_hist[t1+1], 5'b10000);
    check("t1_bandera_at_T1", band_hist[t1+1], 0);
    for (int i = 2; i <= 5; i++) check("t1_bandera_high", band_hist[t1+i], 1);
    check("t1_bandera_at_T6", band_hist[t1+6], 0);

    // Release A: mAccion clears, no strobe
    send_byte(8'hF0);
    send_byte(8'h1C);
    tick(5);
    check("t1_release_clear", mac_hist[last_rxv+1], 0);
    check("t1_release_no_strobe", rises_between(t1 + 3, cyc), 0);

    // Hold left arrow: strobes at T+2, +RPT, +2*RPT
    send_byte(8'hE0);
    send_byte(8'h6B);
    tick(10);
    t2 = last_rxv;
    check("t2_mAccion", mac_hist[t2+1], 5'b00010);
    tick(t2 + 2 * RPT + 50 - cyc);

    // Release left arrow
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h6B);
    tick(5);
    tb3 = last_rxv;
    check("t3_mAccion_before", mac_hist[tb3], 5'b00010);
    check("t3_mAccion_clear", mac_hist[tb3+1], 0);
    tick(RPT + 100);
    check("t2_rise_first", rises_between(t2 + 2, t2 + 2), 1);
    check("t2_rise_second", rises_between(t2 + 2 + RPT, t2 + 2 + RPT), 1);
    check("t2_rise_third", rises_between(t2 + 2 + 2 * RPT, t2 + 2 + 2 * RPT), 1);
    check("t2_rise_count", rises_between(t2, tb3), 3);
    check("t2_mAccion_at_repeat", mac_hist[t2 + 2 + RPT], 5'b00010);
    check("t3_no_new_strobe", rises_between(tb3, cyc), 0);
    check("t3_mAccion_after", mAccion, 0);

    // Bad parity: error pulse only
    n0 = rxv_cnt; f0 = fe_cnt; s0 = rise_cyc.size();
    send_bits(8'h1C, 1'b1, 11);
    tick(H + 10);
    check("t4_frame_err", fe_cnt - f0, 1);
    check("t4_no_rx_valid", rxv_cnt - n0, 0);
    check("t4_no_strobe", rise_cyc.size() - s0, 0);
    check("t4_mAccion", mAccion, 0);
    check("t4_rx_byte_kept", rx_byte, 8'h6B);

    // Partial frame then timeout, then a clean D
    n0 = rxv_cnt; f0 = fe_cnt;
    send_bits(8'h23, 1'b0, 6);
    tick(TMO + 100);
    check("t5_timeout_err", fe_cnt - f0, 1);
    check("t5_no_rx_valid", rxv_cnt - n0, 0);
    send_byte(8'h23);
    tick(10);
    t5 = last_rxv;
    check("t5_rx_valid", rxv_cnt - n0, 1);
    check("t5_rx_byte", rx_byte, 8'h23);
    check("t5_mAccion", mac_hist[t5+1], 5'b01000);
    check("t5_no_extra_err", fe_cnt - f0, 1);
    send_byte(8'hF0);
    send_byte(8'h23);
    tick(5);
    check("t5_release", mAccion, 0);

    // Press A, then finish a D frame just after A's repeat strobe rises
    send_byte(8'h1C);
    tick(5);
    t6 = last_rxv;
    check("t6_mAccion_first", mac_hist[t6+1], 5'b10000);
    tick(t6 + RPT - 470 - cyc);
    send_bits(8'h23, 1'b0, 10);
    wait_cnt = 0;
    while (bandera !== 1'b1 && wait_cnt < 150) begin
      tick(1);
      wait_cnt++;
    end
    check("t6_repeat_rise_seen", bandera, 1);
    r1 = cyc;
    ps2_clk = 1'b0;
    tick(4);
    ps2_clk = 1'b1;
    wait_cnt = 0;
    while (first_rise_after(r1) < 0 && wait_cnt < 40) begin
      tick(1);
      wait_cnt++;
    end
    r2 = first_rise_after(r1);
    t6b = last_rxv;
    check("t6_second_rise_seen", (r2 > 0), 1);
    check("t6_decode_while_busy", (t6b > r1 && t6b < r1 + 2 * BW), 1);
    check("t6_rx_byte", rx_byte, 8'h23);
    check("t6_mAccion_first_rise", mac_hist[r1], 5'b10000);
    check("t6_min_gap", (r2 - r1 >= 2 * BW && r2 - r1 <= 2 * BW + 4), 1);
    check("t6_mAccion_second_rise", mac_hist[r2], 5'b11000);
    check("t6_bandera_high_now", bandera, 1);
    Reset = 1'b1;
    tick(1);
    check("t6_reset_bandera", bandera, 0);
    check("t6_reset_mAccion", mAccion, 0);
    Reset = 1'b0;
    tick(3 * BW);
    check("t6_single_pending_launch", rises_between(r1 + 1, cyc), 1);

    // Random key events against an event-level held-key model
    model = '0;
    for (int i = 0; i < 10; i++) begin
      k = $urandom_range(0, 10);
      if (k < 10) begin
        ki   = k % 5;
        code = KEY_CODE[ki];
        if (KEY_EXT[ki]) send_byte(8'hE0);
        if (k >= 5) send_byte(8'hF0);
        send_byte(code);
        model[KEY_BIT[ki]] = (k < 5);
      end else begin
        do code = 8'($urandom_range(0, 255)); while (is_special(code));
        send_byte(code);
      end
      tick(RPT + 40);
      check("rand_mAccion", mAccion, model);
      check("rand_rx_byte", rx_byte, code);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
